// File: rtl/seg7_scan_if.sv
// ============================================================================
// Module  : seg7_scan_if
// Purpose : Pin-side bundle for the 7-segment scan decoder.
//           Carries the display inputs and the decoded frame outputs.
//           Optional decimal point under SEG7_DP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg7_scan_if;
    logic [6:0]  seg_in;
    logic [3:0]  ann_in;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic [3:0]  blank;
    logic        valid;
    logic        frame_done;
    logic        timeout;
`ifdef SEG7_DP_EN
    logic        dp_in;
    logic [3:0]  dp;

    modport master (output seg_in, ann_in, dp_in,
                    input  value, digit_err, blank, valid, frame_done, timeout, dp);
    modport slave  (input  seg_in, ann_in, dp_in,
                    output value, digit_err, blank, valid, frame_done, timeout, dp);
`else
    modport master (output seg_in, ann_in,
                    input  value, digit_err, blank, valid, frame_done, timeout);
    modport slave  (input  seg_in, ann_in,
                    output value, digit_err, blank, valid, frame_done, timeout);
`endif
endinterface

`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
// ============================================================================
// Module  : seg7_scan_decoder
// Purpose : Samples multiplexed active-low 7-segment/anode pins, decodes each
//           stable digit to a nibble and publishes a 16-bit frame once all four
//           digits are seen. Optional decimal point capture: SEG7_DP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  wire logic  clk,
    input  wire logic  reset,
    seg7_scan_if.slave bus
);

`ifdef SEG7_DP_EN
    localparam int c_SAMPLE_W = 12;
`else
    localparam int c_SAMPLE_W = 11;
`endif
    localparam int                  c_CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam int                  c_TCNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_STABLE   = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_TCNT_W-1:0] c_TMO      = c_TCNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_TCNT_W-1:0] c_TMO_LAST = c_TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    logic [c_SAMPLE_W-1:0] w_pins;
    logic [c_SAMPLE_W-1:0] r_s_q;
    logic [c_SAMPLE_W-1:0] r_s_prev;
    logic [3:0]            w_ann;
    logic [6:0]            w_seg;
    logic                  w_same;
    logic                  w_legal;
    logic [1:0]            w_sel;
    logic [3:0]            w_sel_oh;
    logic [3:0]            w_nib;
    logic                  w_err;
    logic                  w_blank;
    state_t                r_st;
    state_t                w_st_n;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_n;
    logic                  w_capture;
    logic [3:0]            r_seen;
    logic [c_TCNT_W-1:0]   r_tcnt;
    logic [15:0]           w_slot_nib;
    logic [3:0]            w_slot_err;
    logic [3:0]            w_slot_blank;
    logic [15:0]           r_value;
    logic [3:0]            r_digit_err;
    logic [3:0]            r_blank;
    logic                  r_valid;
    logic                  r_frame_done;
    logic                  r_timeout;

`ifdef SEG7_DP_EN
    logic [3:0]            w_slot_dp;
    logic [3:0]            r_dp;
    assign w_pins = {bus.dp_in, bus.seg_in, bus.ann_in};
`else
    assign w_pins = {bus.seg_in, bus.ann_in};
`endif

    // r_s_prev lets the FSM see whether the latest registered sample repeated
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_q    <= '0;
            r_s_prev <= '0;
        end else begin
            r_s_q    <= w_pins;
            r_s_prev <= r_s_q;
        end
    end

    assign w_ann    = r_s_q[3:0];
    assign w_seg    = r_s_q[10:4];
    assign w_same   = (r_s_q == r_s_prev);
    assign w_sel_oh = 4'b0001 << w_sel;

    always_comb begin
        w_legal = 1'b0;
        w_sel   = 2'd0;
        case (w_ann)
            4'b1110: begin w_legal = 1'b1; w_sel = 2'd0; end
            4'b1101: begin w_legal = 1'b1; w_sel = 2'd1; end
            4'b1011: begin w_legal = 1'b1; w_sel = 2'd2; end
            4'b0111: begin w_legal = 1'b1; w_sel = 2'd3; end
            default: begin w_legal = 1'b0; w_sel = 2'd0; end
        endcase
    end

    // B and D alias 8 and 0 on a 7-segment display, so they never appear here
    always_comb begin
        w_nib   = 4'h0;
        w_err   = 1'b0;
        w_blank = 1'b0;
        case (w_seg)
            7'b1000000: w_nib = 4'h0;
            7'b1111001: w_nib = 4'h1;
            7'b0100100: w_nib = 4'h2;
            7'b0110000: w_nib = 4'h3;
            7'b0011001: w_nib = 4'h4;
            7'b0010010: w_nib = 4'h5;
            7'b0000010: w_nib = 4'h6;
            7'b1111000: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0010000: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b1000110: w_nib = 4'hC;
            7'b0000110: w_nib = 4'hE;
            7'b0001110: w_nib = 4'hF;
            7'b1111111: w_blank = 1'b1;
            default:    w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st  <= ST_IDLE;
            r_cnt <= '0;
        end else begin
            r_st  <= w_st_n;
            r_cnt <= w_cnt_n;
        end
    end

    always_comb begin
        w_st_n    = r_st;
        w_cnt_n   = r_cnt;
        w_capture = 1'b0;
        case (r_st)
            ST_IDLE: begin
                if (w_legal) begin
                    w_st_n  = ST_SETTLE;
                    w_cnt_n = c_CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (!w_legal) begin
                    w_st_n = ST_IDLE;
                end else if (!w_same) begin
                    w_cnt_n = c_CNT_ONE;
                end else begin
                    w_cnt_n = r_cnt + c_CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!w_same) begin
                    if (w_legal) begin
                        w_st_n  = ST_SETTLE;
                        w_cnt_n = c_CNT_ONE;
                    end else begin
                        w_st_n = ST_IDLE;
                    end
                end
            end
            default: w_st_n = ST_IDLE;
        endcase
        // A single check covers STABLE_CYCLES==1, where entry itself completes the count
        if (w_st_n == ST_SETTLE && w_cnt_n == c_STABLE) begin
            w_capture = 1'b1;
            w_st_n    = ST_HELD;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_slot
        logic [3:0] r_nib;
        logic       r_err;
        logic       r_blk;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_nib <= 4'h0;
                r_err <= 1'b0;
                r_blk <= 1'b0;
            end else if (w_capture && w_sel == 2'(i)) begin
                r_nib <= w_nib;
                r_err <= w_err;
                r_blk <= w_blank;
            end
        end
        assign w_slot_nib[4*i +: 4] = r_nib;
        assign w_slot_err[i]        = r_err;
        assign w_slot_blank[i]      = r_blk;
`ifdef SEG7_DP_EN
        logic r_dpl;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_dpl <= 1'b0;
            end else if (w_capture && w_sel == 2'(i)) begin
                r_dpl <= ~r_s_q[11];
            end
        end
        assign w_slot_dp[i] = r_dpl;
`endif
    end

    // Publish copies the slots as they stood before this edge; a capture on the same edge starts the next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seen       <= 4'h0;
            r_tcnt       <= '0;
            r_value      <= 16'h0000;
            r_digit_err  <= 4'h0;
            r_blank      <= 4'h0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_timeout    <= 1'b0;
`ifdef SEG7_DP_EN
            r_dp         <= 4'h0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            if (r_seen == 4'hF) begin
                r_value      <= w_slot_nib;
                r_digit_err  <= w_slot_err;
                r_blank      <= w_slot_blank;
                r_valid      <= 1'b1;
                r_frame_done <= 1'b1;
                r_timeout    <= 1'b0;
                r_tcnt       <= '0;
                r_seen       <= w_capture ? w_sel_oh : 4'h0;
`ifdef SEG7_DP_EN
                r_dp         <= w_slot_dp;
`endif
            end else begin
                if (w_capture) begin
                    r_seen <= r_seen | w_sel_oh;
                end
                if (r_tcnt != c_TMO) begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
                if (r_tcnt == c_TMO_LAST) begin
                    r_valid   <= 1'b0;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.value      = r_value;
    assign bus.digit_err  = r_digit_err;
    assign bus.blank      = r_blank;
    assign bus.valid      = r_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.timeout    = r_timeout;
`ifdef SEG7_DP_EN
    assign bus.dp         = r_dp;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
// ============================================================================
// Module  : tb_seg7_scan_decoder
// Purpose : Scoreboard bench for seg7_scan_decoder; frame expectations come
//           from a run-length model of the driven pins. Honours SEG7_DP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_decoder;
    localparam int S   = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   fd_count = 0;
    int   fd_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_scan_if bus ();

    seg7_scan_decoder #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] value;
        logic [3:0]  err;
        logic [3:0]  blank;
        logic [3:0]  dp;
    } frame_t;

    frame_t exp_q[$];

    logic [6:0] pat_tab [14] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                                 7'b0001000, 7'b1000110, 7'b0000110, 7'b0001110};
    logic [3:0] nib_tab [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                                 4'hA, 4'hC, 4'hE, 4'hF};

    logic [3:0]  m_nib [4];
    logic [3:0]  m_err, m_blank, m_dp, m_seen;
    logic [11:0] m_last;
    bit          m_last_ok;
    int          m_run;
    bit          m_captured;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_decode(input logic [6:0] seg, output logic [3:0] nib,
                                         output logic err, output logic blk);
        nib = 4'h0; err = 1'b1; blk = 1'b0;
        if (seg == 7'h7F) begin
            err = 1'b0; blk = 1'b1;
        end else begin
            for (int k = 0; k < 14; k++)
                if (pat_tab[k] == seg) begin nib = nib_tab[k]; err = 1'b0; end
        end
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) m_nib[k] = 4'h0;
        m_err = 0; m_blank = 0; m_dp = 0; m_seen = 0;
        m_last_ok = 0; m_run = 0; m_captured = 0;
        exp_q.delete();
    endtask

    // A run of identical pins captures once, if it lasts at least S samples and selects exactly one digit
    task automatic drive(input logic [6:0] seg, input logic [3:0] ann, input logic dpn, input int dwell);
        logic [11:0] pins;
        int zeros, idx;
        logic [3:0] nib; logic err, blk;
        frame_t f;
`ifdef SEG7_DP_EN
        pins = {dpn, seg, ann};
`else
        pins = {1'b0, seg, ann};
`endif
        if (m_last_ok && pins == m_last) m_run += dwell;
        else begin m_run = dwell; m_captured = 0; end
        m_last = pins; m_last_ok = 1;
        zeros = 0; idx = 0;
        for (int k = 0; k < 4; k++) if (!ann[k]) begin zeros++; idx = k; end
        if (zeros == 1 && !m_captured && m_run >= S) begin
            model_decode(seg, nib, err, blk);
            m_nib[idx] = nib; m_err[idx] = err; m_blank[idx] = blk; m_dp[idx] = ~dpn;
            m_seen[idx] = 1'b1; m_captured = 1;
            if (m_seen == 4'hF) begin
                f.value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                f.err = m_err; f.blank = m_blank; f.dp = m_dp;
                exp_q.push_back(f);
                m_seen = 4'h0;
            end
        end
        bus.seg_in = seg;
        bus.ann_in = ann;
`ifdef SEG7_DP_EN
        bus.dp_in = dpn;
`endif
        repeat (dwell) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                         input logic [6:0] p3, input int dwell);
        drive(p0, 4'b1110, 1'($urandom), dwell);
        drive(p1, 4'b1101, 1'($urandom), dwell);
        drive(p2, 4'b1011, 1'($urandom), dwell);
        drive(p3, 4'b0111, 1'($urandom), dwell);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_value"}, 32'(bus.value), 32'h0);
        check({tag, "_digit_err"}, 32'(bus.digit_err), 32'h0);
        check({tag, "_blank"}, 32'(bus.blank), 32'h0);
        check({tag, "_valid"}, 32'(bus.valid), 32'h0);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 32'h0);
        check({tag, "_timeout"}, 32'(bus.timeout), 32'h0);
`ifdef SEG7_DP_EN
        check({tag, "_dp"}, 32'(bus.dp), 32'h0);
`endif
    endtask

    task automatic do_reset(input string tag);
        bus.seg_in = 7'h7F;
        bus.ann_in = 4'hF;
`ifdef SEG7_DP_EN
        bus.dp_in = 1'b1;
`endif
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        check_zero_outputs(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.frame_done === 1'b1) begin
            frame_t e;
            fd_count++;
            fd_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame: got frame %h, expected no frame (t=%0t)", bus.value, $time);
            end else begin
                e = exp_q.pop_front();
                check("frame_value", 32'(bus.value), 32'(e.value));
                check("frame_digit_err", 32'(bus.digit_err), 32'(e.err));
                check("frame_blank", 32'(bus.blank), 32'(e.blank));
                check("frame_valid", 32'(bus.valid), 32'h1);
                check("frame_timeout", 32'(bus.timeout), 32'h0);
`ifdef SEG7_DP_EN
                check("frame_dp", 32'(bus.dp), 32'(e.dp));
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0, guard;
        logic [3:0] ann;
        logic [6:0] seg;
        reset = 1'b0;
        bus.seg_in = 7'h7F;
        bus.ann_in = 4'hF;
`ifdef SEG7_DP_EN
        bus.dp_in = 1'b1;
`endif
        #2;
        do_reset("reset0");

        // Dwell below the stability window: nothing captured, no frame
        scan4(7'b0110000, 7'b0010010, 7'b0011001, 7'b1111001, 3);
        drive(7'h7F, 4'hF, 1'b1, 8);
        check("short_dwell_valid", 32'(bus.valid), 32'h0);
        check("no_frame_timeout", 32'(bus.timeout), 32'h1);

        scan4(7'b0110000, 7'b0010010, 7'b0011001, 7'b1111001, 6);
        drive(7'h7F, 4'hF, 1'b1, 4);
        check("t1_value", 32'(bus.value), 32'h1453);
        check("t1_valid", 32'(bus.valid), 32'h1);

        scan4(7'b0010010, 7'b0000010, 7'b0101010, 7'b1111111, 6);
        drive(7'h7F, 4'hF, 1'b1, 4);
        check("t3_value", 32'(bus.value), 32'h0065);
        check("t3_digit_err", 32'(bus.digit_err), 32'h4);
        check("t3_blank", 32'(bus.blank), 32'h8);

        // Illegal anode gaps between digits
        drive(7'b0011001, 4'b1110, 1'b1, 6);
        drive(7'b0011001, 4'b1100, 1'b1, 20);
        drive(7'b1000110, 4'b1101, 1'b0, 6);
        drive(7'b1000110, 4'b1111, 1'b1, 20);
        drive(7'b1111001, 4'b1011, 1'b1, 6);
        drive(7'b0000000, 4'b1100, 1'b1, 20);
        drive(7'b0000000, 4'b0111, 1'b0, 6);
        drive(7'h7F, 4'hF, 1'b1, 4);
        check("t4_value", 32'(bus.value), 32'h81C4);

        // Timeout exactly TMO cycles after frame_done, value held
        fd0 = fd_count;
        scan4(7'b0100100, 7'b1111000, 7'b0010000, 7'b0000110, 6);
        drive(7'h7F, 4'hF, 1'b1, 1);
        guard = 0;
        while (fd_count == fd0 && guard < 40) begin @(negedge clk); guard++; end
        check("t5_frame_seen", 32'(fd_count != fd0), 32'h1);
        if (fd_count != fd0) begin
            while (cyc < fd_cyc + TMO - 1) @(negedge clk);
            check("t5_timeout_before", 32'(bus.timeout), 32'h0);
            check("t5_valid_before", 32'(bus.valid), 32'h1);
            @(negedge clk);
            check("t5_timeout_at", 32'(bus.timeout), 32'h1);
            check("t5_valid_at", 32'(bus.valid), 32'h0);
            check("t5_value_held", 32'(bus.value), 32'hE972);
        end
        drive(7'h7F, 4'hF, 1'b1, 6);
        scan4(7'b1000000, 7'b0001110, 7'b0000010, 7'b0110000, 6);
        drive(7'h7F, 4'hF, 1'b1, 3);
        check("t5_timeout_cleared", 32'(bus.timeout), 32'h0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 8) ann = ~(4'b0001 << $urandom_range(0, 3));
            else ann = 4'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: seg = pat_tab[$urandom_range(0, 13)];
                7:       seg = 7'h7F;
                default: seg = 7'($urandom);
            endcase
            drive(seg, ann, 1'($urandom), $urandom_range(2, 7));
        end
        drive(7'h7F, 4'hF, 1'b1, 6);

        // Reset after two digits discards the partial frame
        drive(7'b0000000, 4'b1110, 1'b0, 6);
        drive(7'b0001000, 4'b1101, 1'b1, 6);
        do_reset("reset_mid");
        scan4(7'b0000000, 7'b0001000, 7'b1000110, 7'b0001110, 6);
        drive(7'h7F, 4'hF, 1'b1, 5);
        check("t6_value", 32'(bus.value), 32'hFCA8);
        check("t6_valid", 32'(bus.valid), 32'h1);

        drive(7'h7F, 4'hF, 1'b1, 10);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
